// File: rtl/uart_cmd_parser_if.sv
// UART command parser bus: RX byte strobe in, echo and report/error pulses out.
interface uart_cmd_parser_if;
    logic [7:0] iRxData;
    logic       iRxValid;
    logic [7:0] oLoopData;
    logic       oLoopValid;
    logic       oReqWatchReport;
    logic       oReqSr04Report;
    logic       oReqTempReport;
    logic       oReqHumReport;
    logic       oCmdError;

    // Side that feeds received bytes and consumes the decoder results.
    modport master (
        output iRxData, iRxValid,
        input  oLoopData, oLoopValid,
        input  oReqWatchReport, oReqSr04Report, oReqTempReport, oReqHumReport, oCmdError
    );

    // The parser itself.
    modport slave (
        input  iRxData, iRxValid,
        output oLoopData, oLoopValid,
        output oReqWatchReport, oReqSr04Report, oReqTempReport, oReqHumReport, oCmdError
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Line-based ASCII command decoder. Echoes every RX byte, buffers one line,
// matches WATCH / SR04 / TEMP / HUM case-insensitively and pulses a report
// request, or an error for an unknown or overlong line.
module uart_cmd_parser #(
    parameter int P_MAX_LEN = 8,
    parameter bit P_ECHO_EN = 1'b1
) (
    input logic            iClk,
    input logic            iRst,
    uart_cmd_parser_if.slave bus
);

    localparam int LW = $clog2(P_MAX_LEN + 1);
    localparam logic [LW-1:0] MAX_LEN = LW'(P_MAX_LEN);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DISCARD = 2'd1,
        ST_DECODE  = 2'd2
    } state_t;

    state_t        rState;
    logic [LW-1:0] rLen;
    logic [7:0]    rBuf [P_MAX_LEN];
    logic          rOverflow;   // line being decoded had overflowed

    logic [7:0] rLoopData;
    logic       rLoopValid;
    logic       rReqWatch, rReqSr04, rReqTemp, rReqHum, rCmdError;

    logic [7:0] rxNorm;
    logic       isTerm, isBs;
    logic       hitWatch, hitSr04, hitTemp, hitHum;

    // Classify the incoming byte and fold lowercase letters to uppercase.
    always_comb begin
        rxNorm = bus.iRxData;
        if (bus.iRxData >= 8'h61 && bus.iRxData <= 8'h7A)
            rxNorm = bus.iRxData & 8'hDF;
        isTerm = (bus.iRxData == 8'h0D) || (bus.iRxData == 8'h0A);
        isBs   = (bus.iRxData == 8'h08) || (bus.iRxData == 8'h7F);
    end

    // Keyword matches against the buffered line; length must match exactly.
    always_comb begin
        hitWatch = (rLen == LW'(5)) && rBuf[0] == "W" && rBuf[1] == "A" &&
                   rBuf[2] == "T" && rBuf[3] == "C" && rBuf[4] == "H";
        hitSr04  = (rLen == LW'(4)) && rBuf[0] == "S" && rBuf[1] == "R" &&
                   rBuf[2] == "0" && rBuf[3] == "4";
        hitTemp  = (rLen == LW'(4)) && rBuf[0] == "T" && rBuf[1] == "E" &&
                   rBuf[2] == "M" && rBuf[3] == "P";
        hitHum   = (rLen == LW'(3)) && rBuf[0] == "H" && rBuf[1] == "U" &&
                   rBuf[2] == "M";
    end

    // Echo every sampled byte one cycle later.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rLoopData  <= 8'h00;
            rLoopValid <= 1'b0;
        end else begin
            rLoopValid <= bus.iRxValid & P_ECHO_EN;
            if (bus.iRxValid)
                rLoopData <= bus.iRxData;
        end
    end

    // Line collection / discard / decode state machine with registered pulses.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rState    <= ST_COLLECT;
            rLen      <= '0;
            rOverflow <= 1'b0;
            rReqWatch <= 1'b0;
            rReqSr04  <= 1'b0;
            rReqTemp  <= 1'b0;
            rReqHum   <= 1'b0;
            rCmdError <= 1'b0;
            for (int i = 0; i < P_MAX_LEN; i++)
                rBuf[i] <= 8'h00;
        end else begin
            rReqWatch <= 1'b0;
            rReqSr04  <= 1'b0;
            rReqTemp  <= 1'b0;
            rReqHum   <= 1'b0;
            rCmdError <= 1'b0;
            case (rState)
                ST_COLLECT: begin
                    if (bus.iRxValid) begin
                        if (isTerm) begin
                            // Empty lines (e.g. the LF of a CR LF pair) are ignored.
                            if (rLen != '0)
                                rState <= ST_DECODE;
                        end else if (isBs) begin
                            if (rLen != '0)
                                rLen <= rLen - LW'(1);
                        end else if (rLen == MAX_LEN) begin
                            rState <= ST_DISCARD;
                        end else begin
                            for (int i = 0; i < P_MAX_LEN; i++)
                                if (rLen == LW'(i))
                                    rBuf[i] <= rxNorm;
                            rLen <= rLen + LW'(1);
                        end
                    end
                end
                ST_DISCARD: begin
                    // Reuse the decode cycle so the error lands with the same
                    // latency as a normal decode result.
                    if (bus.iRxValid && isTerm) begin
                        rOverflow <= 1'b1;
                        rState    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (rOverflow)     rCmdError <= 1'b1;
                    else if (hitWatch) rReqWatch <= 1'b1;
                    else if (hitSr04)  rReqSr04  <= 1'b1;
                    else if (hitTemp)  rReqTemp  <= 1'b1;
                    else if (hitHum)   rReqHum   <= 1'b1;
                    else               rCmdError <= 1'b1;
                    rOverflow <= 1'b0;
                    rLen      <= '0;
                    rState    <= ST_COLLECT;
                    // A byte landing here starts the next line; terminators and
                    // backspaces on an empty line have no effect.
                    if (bus.iRxValid && !isTerm && !isBs) begin
                        rBuf[0] <= rxNorm;
                        rLen    <= LW'(1);
                    end
                end
                default: rState <= ST_COLLECT;
            endcase
        end
    end

    assign bus.oLoopData       = rLoopData;
    assign bus.oLoopValid      = rLoopValid;
    assign bus.oReqWatchReport = rReqWatch;
    assign bus.oReqSr04Report  = rReqSr04;
    assign bus.oReqTempReport  = rReqTemp;
    assign bus.oReqHumReport   = rReqHum;
    assign bus.oCmdError       = rCmdError;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed table, hand sequences and random bytes
// checked cycle by cycle against a line-level reference model.
module tb_uart_cmd_parser;

    localparam int MAXLEN = 8;

    // Pulse vector layout: {watch, sr04, temp, hum, error}
    localparam logic [4:0] P_W = 5'b10000;
    localparam logic [4:0] P_S = 5'b01000;
    localparam logic [4:0] P_T = 5'b00100;
    localparam logic [4:0] P_H = 5'b00010;
    localparam logic [4:0] P_E = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nErrors = 0;
    int   nWatch  = 0;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(.P_MAX_LEN(MAXLEN), .P_ECHO_EN(1'b1)) dut (
        .iClk(clk),
        .iRst(rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (line level) ----------------
    logic [7:0] mLine[$];
    bit         mOvf  = 1'b0;
    logic [4:0] mPrev = 5'b0;   // result of the byte sampled on the previous edge

    function automatic logic [4:0] classify();
        string s = "";
        foreach (mLine[i]) s = {s, $sformatf("%c", mLine[i])};
        s = s.toupper();
        if (s == "WATCH") return P_W;
        if (s == "SR04")  return P_S;
        if (s == "TEMP")  return P_T;
        if (s == "HUM")   return P_H;
        return P_E;
    endfunction

    function automatic logic [4:0] modelByte(input logic [7:0] b);
        logic [4:0] e;
        e = 5'b0;
        if (b == 8'h0D || b == 8'h0A) begin
            if (mOvf) e = P_E;
            else if (mLine.size() != 0) e = classify();
            mOvf = 1'b0;
            mLine.delete();
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (!mOvf && mLine.size() > 0) void'(mLine.pop_back());
        end else if (!mOvf) begin
            if (mLine.size() == MAXLEN) mOvf = 1'b1;
            else mLine.push_back(b);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle (called at a negedge), compare after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit useTab, input logic [4:0] tabExp);
        logic [4:0] evtNow, expP, actP;
        bus.iRxValid = v;
        bus.iRxData  = d;
        @(posedge clk);
        evtNow = v ? modelByte(d) : 5'b0;
        expP   = useTab ? tabExp : mPrev;
        mPrev  = evtNow;
        @(negedge clk);
        actP = {bus.oReqWatchReport, bus.oReqSr04Report, bus.oReqTempReport,
                bus.oReqHumReport, bus.oCmdError};
        chk("loopValid", 32'(bus.oLoopValid), 32'(v));
        if (v) chk("loopData", 32'(bus.oLoopData), 32'(d));
        chk("pulses", 32'(actP), 32'(expP));
        if (bus.oReqWatchReport) nWatch++;
        bus.iRxValid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 5'b0);
    endtask

    task automatic sendStr(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            step(1'b1, s[i], 1'b0, 5'b0);
            idle(gap);
        end
    endtask

    task automatic checkAllZero(input string nm);
        chk(nm, 32'({bus.oLoopData, bus.oLoopValid, bus.oReqWatchReport, bus.oReqSr04Report,
                     bus.oReqTempReport, bus.oReqHumReport, bus.oCmdError}), 32'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit         vld;
        logic [7:0] data;
        logic [4:0] expP;
    } vec_t;
    vec_t tab[$];

    function automatic void tabRow(input bit v, input logic [7:0] d, input logic [4:0] e);
        vec_t r;
        r.vld = v; r.data = d; r.expP = e;
        tab.push_back(r);
    endfunction

    function automatic void tabStr(input string s);
        for (int i = 0; i < s.len(); i++) tabRow(1'b1, s[i], 5'b0);
    endfunction

    initial begin
        string kws[8];
        string alpha;
        int    w0;

        // T2: SR04 CR LF -> one SR04 pulse, the LF makes no error
        tabStr("SR04"); tabRow(1'b1, 8'h0D, 5'b0); tabRow(1'b1, 8'h0A, P_S); tabRow(1'b0, 8'h00, 5'b0);
        // T3: unknown keyword, then backspace editing
        tabStr("TEMX"); tabRow(1'b1, 8'h0D, 5'b0); tabRow(1'b0, 8'h00, P_E);
        tabStr("HUMM"); tabRow(1'b1, 8'h08, 5'b0); tabRow(1'b1, 8'h0D, 5'b0); tabRow(1'b0, 8'h00, P_H);
        // T4: overflow then recovery
        tabStr("ABCDEFGHI"); tabRow(1'b1, 8'h0D, 5'b0); tabRow(1'b0, 8'h00, P_E);
        tabStr("TEMP"); tabRow(1'b1, 8'h0D, 5'b0); tabRow(1'b0, 8'h00, P_T);
        // T5: byte during the decode cycle starts the next line
        tabStr("HUM"); tabRow(1'b1, 8'h0D, 5'b0); tabRow(1'b1, "T", P_H);
        tabStr("EMP"); tabRow(1'b1, 8'h0D, 5'b0); tabRow(1'b0, 8'h00, P_T);
        // exact-length boundary: 8 bytes fit, backspace at empty line is harmless
        tabRow(1'b1, 8'h7F, 5'b0); tabStr("abcdefgh"); tabRow(1'b1, 8'h0A, 5'b0); tabRow(1'b0, 8'h00, P_E);

        bus.iRxValid = 1'b0;
        bus.iRxData  = 8'h00;

        // reset state
        repeat (2) @(negedge clk);
        checkAllZero("reset_outputs");
        rst = 1'b0;
        idle(2);

        // T1: lowercase watch, one byte every 4 cycles
        w0 = nWatch;
        sendStr("watch", 3);
        step(1'b1, 8'h0D, 1'b0, 5'b0);
        idle(4);
        chk("t1_watch_count", 32'(nWatch - w0), 32'd1);

        // table-driven T2..T5
        foreach (tab[i]) step(tab[i].vld, tab[i].data, 1'b1, tab[i].expP);
        idle(2);

        // T6: reset mid-line discards the partial line
        w0 = nWatch;
        sendStr("WAT", 0);
        #2 rst = 1'b1;
        #1 checkAllZero("reset_async");
        @(negedge clk);
        checkAllZero("reset_held");
        mLine.delete(); mOvf = 1'b0; mPrev = 5'b0;
        rst = 1'b0;
        sendStr("CH", 0);
        step(1'b1, 8'h0D, 1'b0, 5'b0);
        step(1'b0, 8'h00, 1'b1, P_E);
        idle(2);
        chk("t6_no_watch", 32'(nWatch - w0), 32'd0);

        // random stimulus against the model
        kws[0] = "WATCH"; kws[1] = "watch"; kws[2] = "Sr04"; kws[3] = "SR04";
        kws[4] = "temp";  kws[5] = "TEMP";  kws[6] = "hUm";  kws[7] = "HUMX";
        alpha = "WATCHSR04EMPUwatchsrempu Z9";
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r <= 1)      step(1'b1, (r == 0) ? 8'h0D : 8'h0A, 1'b0, 5'b0);
            else if (r == 2) step(1'b1, ($urandom_range(0, 1) == 0) ? 8'h08 : 8'h7F, 1'b0, 5'b0);
            else if (r == 3) begin
                sendStr(kws[$urandom_range(0, 7)], 0);
                step(1'b1, 8'h0D, 1'b0, 5'b0);
            end else step(1'b1, alpha[$urandom_range(0, alpha.len() - 1)], 1'b0, 5'b0);
            idle($urandom_range(0, 3) == 0 ? 1 : 0);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
